// File: rtl/jesd204_tx_pattern_gen.sv
// Multi-lane JESD204 TX test-pattern source (counter, ramp, PRBS15, constant) aligned to the first SOMF after arming.
// Define JESD204_TX_PATTERN_PRBS_EN to build the PRBS15 mode; without it mode 2 produces the counter pattern.
module jesd204_tx_pattern_gen #(
  parameter int NUM_LANES       = 1,
  parameter int DATA_PATH_WIDTH = 8
) (
  input  logic                                   clk,
  input  logic                                   resetn,
  input  logic                                   cfg_enable,
  input  logic [1:0]                             cfg_mode,
  input  logic [8*DATA_PATH_WIDTH-1:0]           cfg_constant,
  input  logic                                   tx_ready,
  input  logic [DATA_PATH_WIDTH-1:0]             tx_somf,
  output logic [NUM_LANES*8*DATA_PATH_WIDTH-1:0] tx_data,
  output logic                                   tx_valid,
  output logic                                   status_running,
  output logic [31:0]                            status_beat_count
);
  localparam int W = 8 * DATA_PATH_WIDTH;

  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

  state_t                      state;
  logic [1:0]                  mode_q;
  logic [1:0]                  arm_mode;
  logic [1:0]                  mode_use;
  logic [W-1:0]                idx_q;
  logic [W-1:0]                idx_nxt;
  logic [NUM_LANES-1:0][W-1:0] data_nxt;
  logic                        arming;
  logic                        advance;
  logic                        load;
  logic                        unused_somf;

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  function automatic logic [W-1:0] lane_word(input logic [1:0] mode, input logic [W-1:0] n,
                                             input int lane, input logic [W-1:0] prbs,
                                             input logic [W-1:0] konst);
    logic [W-1:0] w;
    w = n;
    case (mode)
      2'd1:
        for (int k = 0; k < DATA_PATH_WIDTH; k++)
          w[k*8 +: 8] = 8'(n[7:0] * DATA_PATH_WIDTH + k + 16 * lane);
      2'd2:    w = prbs;
      2'd3:    w = konst;
      default: w = n;
    endcase
    return w;
  endfunction

  // Only bit 0 marks a beat-aligned multiframe start; the other flags are not needed here.
  assign unused_somf = ^tx_somf[DATA_PATH_WIDTH-1:1];
  assign arming      = (state == ARMED) && tx_ready && tx_somf[0];
  assign advance     = (state == RUN) && tx_ready;
  assign load        = cfg_enable && (arming || advance);
  assign idx_nxt     = arming ? '0 : idx_q + W'(1);
  assign mode_use    = arming ? arm_mode : mode_q;

`ifdef JESD204_TX_PATTERN_PRBS_EN
  assign arm_mode = cfg_mode;

  logic [NUM_LANES-1:0][14:0] lfsr_q;
  logic [NUM_LANES-1:0][14:0] lfsr_nxt;

  // x^15+x^14+1, W bits per beat, first generated bit lands in the MSB.
  function automatic logic [15+W-1:0] prbs_adv(input logic [14:0] s);
    logic [14:0]  st;
    logic [W-1:0] w;
    logic         b;
    st = s;
    w  = '0;
    for (int i = W - 1; i >= 0; i--) begin
      b    = st[14] ^ st[13];
      w[i] = b;
      st   = {st[13:0], b};
    end
    return {st, w};
  endfunction

  always_comb begin
    logic [W-1:0] prbs_w;
    prbs_w   = '0;
    lfsr_nxt = lfsr_q;
    data_nxt = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      {lfsr_nxt[l], prbs_w} = prbs_adv(arming ? (15'h7FFF ^ 15'(l)) : lfsr_q[l]);
      data_nxt[l] = lane_word(mode_use, idx_nxt, l, prbs_w, cfg_constant);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int l = 0; l < NUM_LANES; l++)
        lfsr_q[l] <= 15'h7FFF ^ 15'(l);
    end else if (load) begin
      lfsr_q <= lfsr_nxt;
    end
  end
`else
  assign arm_mode = (cfg_mode == 2'd2) ? 2'd0 : cfg_mode;

  always_comb begin
    data_nxt = '0;
    for (int l = 0; l < NUM_LANES; l++)
      data_nxt[l] = lane_word(mode_use, idx_nxt, l, '0, cfg_constant);
  end
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state             <= IDLE;
      mode_q            <= 2'd0;
      idx_q             <= '0;
      tx_data           <= '0;
      tx_valid          <= 1'b0;
      status_running    <= 1'b0;
      status_beat_count <= '0;
    end else if (!cfg_enable) begin
      // Disable wins over every transition; the beat count is kept for inspection.
      state          <= IDLE;
      tx_data        <= '0;
      tx_valid       <= 1'b0;
      status_running <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state             <= ARMED;
          tx_data           <= '0;
          tx_valid          <= 1'b1;
          status_running    <= 1'b0;
          status_beat_count <= '0;
        end
        ARMED: begin
          if (arming) begin
            state          <= RUN;
            mode_q         <= arm_mode;
            idx_q          <= '0;
            tx_data        <= data_nxt;
            status_running <= 1'b1;
          end
        end
        RUN: begin
          if (advance) begin
            idx_q             <= idx_nxt;
            tx_data           <= data_nxt;
            status_beat_count <= sat_inc(status_beat_count);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_jesd204_tx_pattern_gen.sv
// Directed bench for jesd204_tx_pattern_gen: 2 lanes, 4 octets per lane (W=32).
// PRBS expectations follow JESD204_TX_PATTERN_PRBS_EN when it is defined for the build.
module tb_jesd204_tx_pattern_gen;
  localparam int NL  = 2;
  localparam int DPW = 4;
  localparam int W   = 8 * DPW;
  localparam logic [W-1:0] K = 32'hA5C3_0F1E;

  logic            clk = 1'b0;
  logic            resetn;
  logic            cfg_enable;
  logic [1:0]      cfg_mode;
  logic [W-1:0]    cfg_constant;
  logic            tx_ready;
  logic [DPW-1:0]  tx_somf;
  logic [NL*W-1:0] tx_data;
  logic            tx_valid;
  logic            status_running;
  logic [31:0]     status_beat_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  jesd204_tx_pattern_gen #(.NUM_LANES(NL), .DATA_PATH_WIDTH(DPW)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .cfg_enable        (cfg_enable),
    .cfg_mode          (cfg_mode),
    .cfg_constant      (cfg_constant),
    .tx_ready          (tx_ready),
    .tx_somf           (tx_somf),
    .tx_data           (tx_data),
    .tx_valid          (tx_valid),
    .status_running    (status_running),
    .status_beat_count (status_beat_count)
  );

  typedef struct {
    logic           en;
    logic [1:0]     mode;
    logic           rdy;
    logic [DPW-1:0] somf;
    logic [W-1:0]   d0;
    logic [W-1:0]   d1;
    logic           vld;
    logic           run;
    logic [31:0]    cnt;
  } vec_t;

  vec_t tbl[$];

`ifdef JESD204_TX_PATTERN_PRBS_EN
  localparam int PRBS_BEATS = 4096;
  bit stream [0:15+32*PRBS_BEATS-1];

  function automatic logic [31:0] model_word(input int n);
    logic [31:0] w;
    for (int j = 0; j < 32; j++) w[31-j] = stream[15 + 32*n + j];
    return w;
  endfunction
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic [1:0] mode, input logic rdy, input logic [DPW-1:0] somf,
                     input logic [W-1:0] d0, input logic [W-1:0] d1, input logic vld, input logic run,
                     input logic [31:0] cnt);
    vec_t v;
    v.en = en; v.mode = mode; v.rdy = rdy; v.somf = somf;
    v.d0 = d0; v.d1 = d1; v.vld = vld; v.run = run; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic en, input logic [1:0] mode, input logic rdy, input logic [DPW-1:0] somf);
    cfg_enable = en;
    cfg_mode   = mode;
    tx_ready   = rdy;
    tx_somf    = somf;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [W-1:0] d0, input logic [W-1:0] d1,
                           input logic vld, input logic run, input logic [31:0] cnt);
    chk({tag, " lane0"},   tx_data[W-1:0],     d0);
    chk({tag, " lane1"},   tx_data[2*W-1:W],   d1);
    chk({tag, " valid"},   {31'd0, tx_valid},       {31'd0, vld});
    chk({tag, " running"}, {31'd0, status_running}, {31'd0, run});
    chk({tag, " count"},   status_beat_count,  cnt);
  endtask

  initial begin
    // Arm, align, count, stall, ignore mode change and late SOMF, disable, ramp, constant.
    add(1, 0, 1, 4'h0, 0, 0, 1, 0, 0);
    add(1, 0, 1, 4'hE, 0, 0, 1, 0, 0);
    add(1, 0, 1, 4'h0, 0, 0, 1, 0, 0);
    add(1, 0, 1, 4'h1, 0, 0, 1, 1, 0);
    for (int k = 1; k <= 7; k++) add(1, 0, 1, 4'h0, k, k, 1, 1, k);
    for (int k = 0; k < 3; k++)  add(1, 0, 0, 4'h0, 7, 7, 1, 1, 7);
    add(1, 0, 1, 4'h0, 8, 8, 1, 1, 8);
    add(1, 0, 1, 4'h1, 9, 9, 1, 1, 9);
    add(1, 1, 1, 4'h0, 10, 10, 1, 1, 10);
    add(0, 1, 1, 4'h0, 0, 0, 0, 0, 10);
    add(0, 1, 1, 4'h1, 0, 0, 0, 0, 10);
    add(1, 1, 1, 4'h0, 0, 0, 1, 0, 0);
    add(1, 1, 1, 4'h1, 32'h03020100, 32'h13121110, 1, 1, 0);
    add(1, 1, 1, 4'h0, 32'h07060504, 32'h17161514, 1, 1, 1);
    add(1, 1, 0, 4'h0, 32'h07060504, 32'h17161514, 1, 1, 1);
    add(1, 3, 1, 4'h0, 32'h0B0A0908, 32'h1B1A1918, 1, 1, 2);
    add(0, 3, 1, 4'h0, 0, 0, 0, 0, 2);
    add(1, 3, 0, 4'h0, 0, 0, 1, 0, 0);
    add(1, 3, 0, 4'h1, 0, 0, 1, 0, 0);
    add(1, 3, 1, 4'h1, K, K, 1, 1, 0);
    add(1, 3, 1, 4'h0, K, K, 1, 1, 1);
    add(0, 3, 1, 4'h0, 0, 0, 0, 0, 1);

`ifdef JESD204_TX_PATTERN_PRBS_EN
    for (int i = 0; i < 15; i++) stream[i] = 1'b1;
    for (int i = 15; i < 15 + 32*PRBS_BEATS; i++) stream[i] = stream[i-15] ^ stream[i-14];
`endif

    resetn       = 1'b0;
    cfg_enable   = 1'b0;
    cfg_mode     = 2'd0;
    cfg_constant = K;
    tx_ready     = 1'b0;
    tx_somf      = '0;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 0, 0, 0, 0, 0);
    resetn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].en, tbl[i].mode, tbl[i].rdy, tbl[i].somf);
      check_out($sformatf("row%0d", i), tbl[i].d0, tbl[i].d1, tbl[i].vld, tbl[i].run, tbl[i].cnt);
    end

    // Reset in the middle of a run at count 100.
    drive(1, 0, 1, 4'h0);
    drive(1, 0, 1, 4'h1);
    for (int k = 0; k < 100; k++) drive(1, 0, 1, 4'h0);
    check_out("run100", 100, 100, 1, 1, 100);
    resetn = 1'b0;
    drive(1, 0, 1, 4'h0);
    check_out("midreset", 0, 0, 0, 0, 0);
    resetn = 1'b1;
    drive(1, 0, 1, 4'h0);
    check_out("rearm", 0, 0, 1, 0, 0);
    drive(1, 0, 1, 4'h1);
    check_out("restart", 0, 0, 1, 1, 0);

    // Mode 2 from a fresh arm.
    drive(0, 0, 1, 4'h0);
    drive(1, 2, 1, 4'h0);
    drive(1, 2, 1, 4'h1);
`ifdef JESD204_TX_PATTERN_PRBS_EN
    chk("prbs lane0 first", tx_data[W-1:0],   32'h0002000C);
    chk("prbs lane1 first", tx_data[2*W-1:W], 32'h00040018);
    for (int n = 0; n < PRBS_BEATS; n++) begin
      chk($sformatf("prbs lane0 beat%0d", n), tx_data[W-1:0], model_word(n));
      drive(1, 2, 1, 4'h0);
    end
`else
    for (int n = 0; n < 16; n++) begin
      chk($sformatf("mode2 lane0 beat%0d", n), tx_data[W-1:0],   n);
      chk($sformatf("mode2 lane1 beat%0d", n), tx_data[2*W-1:W], n);
      drive(1, 2, 1, 4'h0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
